// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared state encoding and widths for the waveform capture block
package wave_pkg;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } wave_state_t;

    localparam int DISPLAY_W  = 8;
    localparam int RAM_ADDR_W = 9;

endpackage

// File: rtl/zero_cross_detect.sv
// rtl/zero_cross_detect.sv - flags a negative-to-non-negative transition between two signed samples
module zero_cross_detect #(
    parameter int SAMPLE_W = 16
) (
    input  logic [SAMPLE_W-1:0] prev_sample,
    input  logic [SAMPLE_W-1:0] cur_sample,
    output logic                rising
);

    // Two's complement: the sign bit alone decides < 0 versus >= 0.
    assign rising = prev_sample[SAMPLE_W-1] & ~cur_sample[SAMPLE_W-1];

endmodule

// File: rtl/wave_capture.sv
// rtl/wave_capture.sv - double-buffered triggered audio capture; optional auto-trigger via WAVE_CAPTURE_TIMEOUT_EN
module wave_capture
    import wave_pkg::*;
#(
    parameter int SAMPLE_W        = 16,
    parameter int CAP_DEPTH_LOG2  = 8,
    parameter int TIMEOUT_SAMPLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      new_sample_ready,
    input  logic [SAMPLE_W-1:0]       new_sample_in,
    input  logic                      wave_display_idle,
    output logic [CAP_DEPTH_LOG2:0]   write_address,
    output logic                      write_enable,
    output logic [DISPLAY_W-1:0]      write_sample,
    output logic                      read_index
);

    wave_state_t               state, next_state;
    logic [CAP_DEPTH_LOG2-1:0] count, next_count;
    logic [SAMPLE_W-1:0]       prev_sample;
    logic                      next_read_index;
    logic                      next_write_enable;
    logic [CAP_DEPTH_LOG2:0]   next_write_address;
    logic [DISPLAY_W-1:0]      next_write_sample;
    logic                      rising;

`ifdef WAVE_CAPTURE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_SAMPLES + 1);
    logic [TO_W-1:0] timeout_cnt, next_timeout_cnt;
`endif

    zero_cross_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_zero_cross_detect (
        .prev_sample (prev_sample),
        .cur_sample  (new_sample_in),
        .rising      (rising)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ARMED;
            count         <= '0;
            prev_sample   <= '0;
            read_index    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
            timeout_cnt   <= '0;
`endif
        end else begin
            state         <= next_state;
            count         <= next_count;
            read_index    <= next_read_index;
            write_enable  <= next_write_enable;
            write_address <= next_write_address;
            write_sample  <= next_write_sample;
            if (new_sample_ready) begin
                prev_sample <= new_sample_in;
            end
`ifdef WAVE_CAPTURE_TIMEOUT_EN
            timeout_cnt   <= next_timeout_cnt;
`endif
        end
    end

    always_comb begin
        next_state         = state;
        next_count         = count;
        next_read_index    = read_index;
        next_write_enable  = 1'b0;
        next_write_address = write_address;
        next_write_sample  = write_sample;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
        next_timeout_cnt   = timeout_cnt;
`endif
        case (state)
            ARMED: begin
                if (new_sample_ready) begin
                    if (rising) begin
                        next_state = ACTIVE;
                        next_count = '0;
                    end
`ifdef WAVE_CAPTURE_TIMEOUT_EN
                    else if (timeout_cnt == TO_W'(TIMEOUT_SAMPLES - 1)) begin
                        next_state = ACTIVE;
                        next_count = '0;
                    end else begin
                        next_timeout_cnt = timeout_cnt + TO_W'(1);
                    end
`endif
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    // Fill the half the display is not reading; offset-binary for the display.
                    next_write_enable  = 1'b1;
                    next_write_address = {~read_index, count};
                    next_write_sample  = {~new_sample_in[SAMPLE_W-1],
                                          new_sample_in[SAMPLE_W-2 -: DISPLAY_W-1]};
                    next_count         = count + 1'b1;
                    if (count == '1) begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wave_display_idle) begin
                    next_read_index = ~read_index;
                    next_state      = ARMED;
                end
            end
            default: begin
                next_state = ARMED;
            end
        endcase
`ifdef WAVE_CAPTURE_TIMEOUT_EN
        if (next_state != ARMED) begin
            next_timeout_cnt = '0;
        end
`endif
    end

endmodule

// File: tb/tb_wave_capture.sv
// tb/tb_wave_capture.sv - directed self-checking bench for wave_capture
module tb_wave_capture;
    import wave_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    int vectors  = 0;
    int errors   = 0;
    int wr_count = 0;

    wave_capture dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write_enable === 1'b1) wr_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic strobe(input logic [15:0] v);
        @(negedge clk);
        new_sample_ready = 1'b1;
        new_sample_in    = v;
        @(negedge clk);
        new_sample_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; new_sample_ready = 1'b0; new_sample_in = '0; wave_display_idle = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", write_enable); end
        vectors++; if (write_address !== 9'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", write_address); end
        vectors++; if (write_sample !== 8'd0) begin errors++; $display("FAIL reset_ws got %h want 00", write_sample); end
        vectors++; if (read_index !== 1'b0) begin errors++; $display("FAIL reset_ri got %b want 0", read_index); end
        vectors++; if (dut.state !== ARMED) begin errors++; $display("FAIL reset_state got %0d want ARMED", dut.state); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_trigger;
        int w0;
        w0 = wr_count;
        strobe(16'hFFFB);
        vectors++; if (dut.state !== ARMED) begin errors++; $display("FAIL trig_neg_state got %0d want ARMED", dut.state); end
        strobe(16'd3);
        vectors++; if (dut.state !== ACTIVE) begin errors++; $display("FAIL trig_state got %0d want ACTIVE", dut.state); end
        vectors++; if (write_enable !== 1'b0) begin errors++; $display("FAIL trig_we got %b want 0", write_enable); end
        @(negedge clk);
        vectors++; if (wr_count != w0) begin errors++; $display("FAIL trig_nowrite got %0d want %0d", wr_count, w0); end
    endtask

    task automatic test_capture_first;
        int w0;
        w0 = wr_count;
        for (int i = 0; i < 256; i++) begin
            strobe(16'h1234);
            vectors++; if (write_enable !== 1'b1) begin errors++; $display("FAIL cap1_we[%0d] got %b want 1", i, write_enable); end
            vectors++; if (write_address !== 9'(256 + i)) begin errors++; $display("FAIL cap1_addr[%0d] got %0d want %0d", i, write_address, 256 + i); end
            vectors++; if (write_sample !== 8'h92) begin errors++; $display("FAIL cap1_ws[%0d] got %h want 92", i, write_sample); end
            @(negedge clk);
            vectors++; if (write_enable !== 1'b0) begin errors++; $display("FAIL cap1_pulse[%0d] got %b want 0", i, write_enable); end
        end
        vectors++; if (wr_count - w0 != 256) begin errors++; $display("FAIL cap1_count got %0d want 256", wr_count - w0); end
        vectors++; if (dut.state !== WAIT) begin errors++; $display("FAIL cap1_state got %0d want WAIT", dut.state); end
        vectors++; if (read_index !== 1'b0) begin errors++; $display("FAIL cap1_ri got %b want 0", read_index); end
    endtask

    task automatic test_wait;
        int w0;
        w0 = wr_count;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            new_sample_ready = (i % 4 == 0);
            new_sample_in    = (i % 8 == 0) ? 16'hFFFB : 16'd3;
        end
        @(negedge clk);
        new_sample_ready = 1'b0;
        vectors++; if (wr_count != w0) begin errors++; $display("FAIL wait_nowrite got %0d want %0d", wr_count, w0); end
        vectors++; if (read_index !== 1'b0) begin errors++; $display("FAIL wait_ri got %b want 0", read_index); end
        vectors++; if (dut.state !== WAIT) begin errors++; $display("FAIL wait_state got %0d want WAIT", dut.state); end
        // Idle rises together with a crossing strobe: toggle, but no trigger.
        wave_display_idle = 1'b1;
        new_sample_ready  = 1'b1;
        new_sample_in     = 16'd3;
        @(negedge clk);
        new_sample_ready  = 1'b0;
        wave_display_idle = 1'b0;
        vectors++; if (read_index !== 1'b1) begin errors++; $display("FAIL toggle_ri got %b want 1", read_index); end
        vectors++; if (dut.state !== ARMED) begin errors++; $display("FAIL toggle_state got %0d want ARMED", dut.state); end
        vectors++; if (write_enable !== 1'b0) begin errors++; $display("FAIL toggle_we got %b want 0", write_enable); end
    endtask

    task automatic test_capture_second;
        int w0;
        logic [7:0] b;
        strobe(16'hFFFB);
        strobe(16'd3);
        vectors++; if (dut.state !== ACTIVE) begin errors++; $display("FAIL cap2_trig got %0d want ACTIVE", dut.state); end
        w0 = wr_count;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            if (i == 255) wave_display_idle = 1'b1;
            strobe({b, 8'h5A});
            vectors++; if (write_enable !== 1'b1) begin errors++; $display("FAIL cap2_we[%0d] got %b want 1", i, write_enable); end
            vectors++; if (write_address !== 9'(i)) begin errors++; $display("FAIL cap2_addr[%0d] got %0d want %0d", i, write_address, i); end
            vectors++; if (write_sample !== (b ^ 8'h80)) begin errors++; $display("FAIL cap2_ws[%0d] got %h want %h", i, write_sample, b ^ 8'h80); end
            if (i == 255) begin
                vectors++; if (dut.state !== WAIT) begin errors++; $display("FAIL cap2_wait got %0d want WAIT", dut.state); end
                vectors++; if (read_index !== 1'b1) begin errors++; $display("FAIL cap2_ri_hold got %b want 1", read_index); end
            end
            @(negedge clk);
        end
        wave_display_idle = 1'b0;
        vectors++; if (wr_count - w0 != 256) begin errors++; $display("FAIL cap2_count got %0d want 256", wr_count - w0); end
        vectors++; if (read_index !== 1'b0) begin errors++; $display("FAIL cap2_ri_toggle got %b want 0", read_index); end
        vectors++; if (dut.state !== ARMED) begin errors++; $display("FAIL cap2_armed got %0d want ARMED", dut.state); end
    endtask

    task automatic test_reset_mid;
        int w0;
        strobe(16'hFFFB);
        strobe(16'd3);
        for (int i = 0; i < 10; i++) strobe(16'h7F00);
        vectors++; if (write_enable !== 1'b1) begin errors++; $display("FAIL mid_we got %b want 1", write_enable); end
        vectors++; if (write_address !== 9'd265) begin errors++; $display("FAIL mid_addr got %0d want 265", write_address); end
        vectors++; if (write_sample !== 8'hFF) begin errors++; $display("FAIL mid_ws got %h want ff", write_sample); end
        reset = 1'b0;
        #1;
        vectors++; if (write_enable !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", write_enable); end
        vectors++; if (write_address !== 9'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", write_address); end
        vectors++; if (write_sample !== 8'd0) begin errors++; $display("FAIL rst_ws got %h want 00", write_sample); end
        vectors++; if (read_index !== 1'b0) begin errors++; $display("FAIL rst_ri got %b want 0", read_index); end
        vectors++; if (dut.state !== ARMED) begin errors++; $display("FAIL rst_state got %0d want ARMED", dut.state); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        w0 = wr_count;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (write_enable !== 1'b0) begin errors++; $display("FAIL rel_we got %b want 0", write_enable); end
        vectors++; if (wr_count != w0) begin errors++; $display("FAIL rel_nowrite got %0d want %0d", wr_count, w0); end
        vectors++; if (dut.state !== ARMED) begin errors++; $display("FAIL rel_state got %0d want ARMED", dut.state); end
    endtask

    task automatic test_timeout;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 1023; i++) strobe(16'd100);
        vectors++; if (dut.state !== ARMED) begin errors++; $display("FAIL to_early got %0d want ARMED", dut.state); end
        strobe(16'd100);
`ifdef WAVE_CAPTURE_TIMEOUT_EN
        vectors++; if (dut.state !== ACTIVE) begin errors++; $display("FAIL to_fire got %0d want ACTIVE", dut.state); end
`else
        vectors++; if (dut.state !== ARMED) begin errors++; $display("FAIL to_none got %0d want ARMED", dut.state); end
`endif
        vectors++; if (write_enable !== 1'b0) begin errors++; $display("FAIL to_we got %b want 0", write_enable); end
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_capture_first();
        test_wait();
        test_capture_second();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
- REQ-001 The block SHALL have parameter SAMPLE_W, default 16, meaning the width of the signed input audio sample.
- REQ-002 The block SHALL have parameter CAP_DEPTH_LOG2, default 8, meaning log2 of the samples captured per half-buffer (256).
- REQ-003 The block SHALL have parameter TIMEOUT_SAMPLES, default 1024, meaning the samples spent in ARMED before an auto-trigger (used only with the macro).
- REQ-004 The block SHALL have port clk  input  1  system clock, with all logic on the rising edge.
- REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset.
- REQ-006 The block SHALL have port new_sample_ready  input  1  single-cycle strobe marking new_sample_in valid.
- REQ-007 The block SHALL have port new_sample_in  input  SAMPLE_W  signed two's-complement audio sample.
- REQ-008 The block SHALL have port wave_display_idle  input  1  high while the display is outside the active waveform region.
- REQ-009 The block SHALL have port write_address  output  CAP_DEPTH_LOG2+1  sample RAM write address, formed as {~read_index, count}.
- REQ-010 The block SHALL have port write_enable  output  1  single-cycle RAM write strobe.
- REQ-011 The block SHALL have port write_sample  output  8  offset-binary display sample.
- REQ-012 The block SHALL have port read_index  output  1  selects the RAM half that wave_display reads.

Function
- REQ-013 The FSM SHALL have three states, ARMED, ACTIVE and WAIT, and SHALL enter ARMED on reset.
- REQ-014 On every new_sample_ready strobe, in any state, a prev_sample register SHALL load new_sample_in.
- REQ-015 In ARMED, a strobe with prev_sample < 0 and new_sample_in >= 0 (rising zero crossing) SHALL move the FSM to ACTIVE with count = 0.
- REQ-016 The triggering sample in REQ-015 SHALL NOT be written to the RAM.
- REQ-017 In ACTIVE, each strobe SHALL cause write_enable = 1 for exactly one cycle, starting the cycle after the strobe.
- REQ-018 During the write in REQ-017, write_sample SHALL equal new_sample_in[SAMPLE_W-1 -: 8] with its MSB inverted.
- REQ-019 During the write in REQ-017, write_address SHALL be {~read_index, count}, and count SHALL increment after the write.
- REQ-020 In ACTIVE, the write at count = 2^CAP_DEPTH_LOG2 - 1 SHALL wrap count to 0 and move the FSM to WAIT.
- REQ-021 In WAIT, strobes SHALL NOT cause writes.
- REQ-022 In WAIT, the first cycle with wave_display_idle = 1 SHALL toggle read_index and move the FSM to ARMED in the same edge.
- REQ-023 If wave_display_idle is already high on entry to WAIT, the toggle SHALL occur on the next cycle.
- REQ-024 read_index SHALL change only on the WAIT->ARMED transition, so the half being written is never the half being displayed.
- REQ-025 A strobe that coincides with the WAIT->ARMED edge SHALL update prev_sample and SHALL NOT trigger.
- REQ-026 Outside a write cycle, write_enable SHALL be 0 and write_address/write_sample SHALL hold their last values.

Reset
- REQ-027 Asserting reset SHALL immediately force state = ARMED, count = 0, prev_sample = 0, read_index = 0, write_enable = 0, write_address = 0, write_sample = 0 and the timeout counter = 0.
- REQ-028 Reset asserted mid-ACTIVE SHALL abandon the partial capture, and no write SHALL occur in the cycle after reset is released.

Configuration
- REQ-029 With WAVE_CAPTURE_TIMEOUT_EN defined, a counter SHALL count strobes while in ARMED and clear on leaving ARMED.
- REQ-030 With WAVE_CAPTURE_TIMEOUT_EN defined, when that counter reaches TIMEOUT_SAMPLES the FSM SHALL enter ACTIVE as if triggered, so silence or DC still refreshes the display.
- REQ-031 With WAVE_CAPTURE_TIMEOUT_EN undefined, the counter SHALL be absent and ARMED SHALL exit only on a zero crossing.

Structure
- REQ-032 Shared package wave_pkg SHALL hold the state enum (ARMED, ACTIVE, WAIT), the display sample width constant (8) and the RAM address width constant.
- REQ-033 The crossing detector SHALL be the sub-module zero_cross_detect (inputs prev/current sample, output rising flag); all other logic SHALL stay in wave_capture.

Verification
- REQ-034 The bench SHALL check: reset low then high, strobes of -5 then +3 -> ARMED->ACTIVE, no write for the +3 sample.
- REQ-035 The bench SHALL check: 256 strobes of 0x1234 in ACTIVE -> 256 write_enable pulses, write_sample = 0x92, addresses 256..511, then state WAIT.
- REQ-036 The bench SHALL check: WAIT with wave_display_idle = 0 for 100 cycles plus strobes -> no writes and read_index stays 0; idle = 1 -> read_index = 1 and state ARMED next edge.
- REQ-037 The bench SHALL check: a second capture after the toggle -> writes at addresses 0..255.
- REQ-038 The bench SHALL check: reset asserted after 10 writes -> all outputs 0 at once and state ARMED.
- REQ-039 The bench SHALL check: with WAVE_CAPTURE_TIMEOUT_EN defined, 1024 strobes of +100 (no crossing) -> ACTIVE entered, and with the macro undefined -> remains ARMED.
